// File: rtl/activation_out_collector.sv
// Return-path collector: captures staggered per-lane results from the systolic array
// into per-lane column buffers and serves them back to the host as packed lane pairs.

module aoc_lane #(
    parameter int DW = 16,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] base,
    input  logic [5:0]    batch,
    input  logic          en,
    input  logic          valid,
    input  logic [DW-1:0] data,
    output logic          complete,
    output logic          err,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] ptr;
    logic [5:0]    cnt;
    logic          wr;

    assign complete = (cnt == batch);
    assign wr       = en && valid && !complete;
    // Any strobe that does not turn into a write is an overrun and its data is dropped.
    assign err      = valid && !wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (load) begin
            ptr <= base;
            cnt <= '0;
        end else if (wr) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt + 1'b1;
        end
    end

    // Simple dual-port RAM; the NBA on both ports gives read-first on a collision.
    always_ff @(posedge clk) begin
        if (wr)
            mem[ptr] <= data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end
endmodule

module activation_out_collector #(
    parameter int LANES  = 32,
    parameter int DW     = 16,
    parameter int AW     = 11,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [4:0]          last_row,
    input  logic [AW-1:0]       addr_start,
    input  logic [5:0]          batch,
    input  logic [LANES*DW-1:0] result_out,
    input  logic [LANES-1:0]    result_out_valid,
    input  logic                s_en,
    input  logic [16:0]         s_addr,
    output logic [31:0]         s_dout,
    output logic                busy,
    output logic                done,
    output logic                overrun
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                           state, state_nxt;
    logic [4:0]                       last_row_q;
    logic [5:0]                       batch_q;
    logic                             load;
    logic [LANES-1:0]                 active, complete, lane_err;
    logic [LANES-1:0][DW-1:0]         rd_data;
    logic [LANES/2-1:0][2*DW-1:0]     rd_pairs;
    logic [RD_LAT-1:1]                vld_q;
    logic [RD_LAT-1:0]                vld_pipe;
    logic [3:0]                       pair_q;
    logic                             unused_addr;

    assign load        = start && (state != COLLECT);
    assign busy        = (state == COLLECT);
    assign done        = (state == DONE);
    assign vld_pipe    = {vld_q, s_en};
    assign rd_pairs    = rd_data;
    assign unused_addr = ^s_addr[1:0];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign active[i] = (32'(i) <= 32'(last_row_q));
        aoc_lane #(.DW(DW), .AW(AW)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .base     (addr_start),
            .batch    (batch_q),
            .en       ((state == COLLECT) && active[i]),
            .valid    (result_out_valid[i]),
            .data     (result_out[i*DW +: DW]),
            .complete (complete[i]),
            .err      (lane_err[i]),
            .rd_en    (s_en),
            .rd_addr  (s_addr[6 +: AW]),
            .rd_data  (rd_data[i])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = COLLECT;
            COLLECT:    if (&(complete | ~active)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // A new start wipes the sticky error from the previous collection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_row_q <= '0;
            batch_q    <= '0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                last_row_q <= last_row;
                batch_q    <= batch;
                overrun    <= 1'b0;
            end else if (|lane_err) begin
                overrun <= 1'b1;
            end
        end
    end

    // RAM output register is the first read stage; the pair mux lands in s_dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            pair_q <= '0;
            s_dout <= '0;
        end else begin
            vld_q <= vld_pipe[RD_LAT-2:0];
            if (s_en)
                pair_q <= s_addr[5:2];
            if (vld_pipe[RD_LAT-1])
                s_dout <= rd_pairs[pair_q];
        end
    end
endmodule

// File: tb/tb_activation_out_collector.sv
// Directed bench for activation_out_collector; expected values worked out by hand.

module tb_activation_out_collector;
    localparam int LANES = 32;
    localparam int DW    = 16;
    localparam int AW    = 11;

    logic                clk = 1'b0;
    logic                reset, start, s_en;
    logic [4:0]          last_row;
    logic [AW-1:0]       addr_start;
    logic [5:0]          batch;
    logic [LANES*DW-1:0] result_out;
    logic [LANES-1:0]    result_out_valid;
    logic [16:0]         s_addr;
    logic [31:0]         s_dout, d;
    logic                busy, done, overrun;
    int                  nvec = 0;
    int                  nerr = 0;

    always #5 clk = ~clk;

    activation_out_collector dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .last_row         (last_row),
        .addr_start       (addr_start),
        .batch            (batch),
        .result_out       (result_out),
        .result_out_valid (result_out_valid),
        .s_en             (s_en),
        .s_addr           (s_addr),
        .s_dout           (s_dout),
        .busy             (busy),
        .done             (done),
        .overrun          (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags packed as {busy, done, overrun}
    function automatic logic [31:0] flags();
        return {29'b0, busy, done, overrun};
    endfunction

    function automatic logic [16:0] wa(input int w, input int k);
        return 17'((w << 6) | (k << 2));
    endfunction

    task automatic go(input logic [4:0] lr, input logic [AW-1:0] a, input logic [5:0] b);
        last_row = lr; addr_start = a; batch = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic lane0(input logic [15:0] v);
        result_out_valid = '0; result_out_valid[0] = 1'b1; result_out[15:0] = v;
        tick();
        result_out_valid = '0;
    endtask

    task automatic rd(input logic [16:0] a, output logic [31:0] q);
        s_en = 1'b1; s_addr = a;
        tick();
        s_en = 1'b0;
        tick();
        q = s_dout;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; s_en = 1'b0; s_addr = '0;
        last_row = '0; addr_start = '0; batch = '0;
        result_out = '0; result_out_valid = '0;
        tick(); tick();
        chk("reset_flags", flags(), 32'b000);
        chk("reset_dout", s_dout, 32'h0);
        reset = 1'b0;
        tick();

        // Basic: lane i streams i*16+n for 4 cycles starting at cycle i
        go(5'd31, 11'd0, 6'd4);
        chk("basic_busy", flags(), 32'b100);
        for (int c = 0; c < 35; c++) begin
            result_out_valid = '0;
            for (int i = 0; i < LANES; i++)
                if (c >= i && c < i + 4) begin
                    result_out_valid[i] = 1'b1;
                    result_out[i*DW +: DW] = 16'(i*16 + c - i);
                end
            tick();
        end
        result_out_valid = '0;
        chk("basic_last_write", flags(), 32'b100);
        tick();
        chk("basic_done", flags(), 32'b010);
        // pair 1 = {lane3, lane2} of word 0
        s_en = 1'b1; s_addr = 17'h4;
        tick();
        s_en = 1'b0;
        chk("rd_lat_hold", s_dout, 32'h0);
        tick();
        chk("basic_rd_pair1", s_dout, 32'h0030_0020);
        rd(17'h0, d);            chk("basic_rd_pair0", d, 32'h0010_0000);
        rd(wa(3, 15), d);        chk("basic_rd_w3p15", d, 32'h01F3_01E3);

        // Partial: lanes 0..3 active, lane 5 strays once
        go(5'd3, 11'd0, 6'd2);
        result_out_valid = '0;
        for (int i = 0; i < 4; i++) begin
            result_out_valid[i] = 1'b1; result_out[i*DW +: DW] = 16'(16'h100 + i);
        end
        result_out_valid[5] = 1'b1; result_out[5*DW +: DW] = 16'hDEAD;
        tick();
        chk("part_overrun", flags(), 32'b101);
        result_out_valid[5] = 1'b0;
        for (int i = 0; i < 4; i++) result_out[i*DW +: DW] = 16'(16'h200 + i);
        tick();
        result_out_valid = '0;
        tick();
        chk("part_done", flags(), 32'b011);
        rd(wa(0, 2), d);         chk("part_lane5_kept", d, 32'h0050_0040);
        rd(wa(1, 0), d);         chk("part_w1p0", d, 32'h0201_0200);

        // Wrap: 2046, 2047, 0 (lane 1 word 0 still holds 0x101)
        go(5'd0, 11'd2046, 6'd3);
        lane0(16'hA); lane0(16'hB); lane0(16'hC);
        chk("wrap_busy", flags(), 32'b100);
        tick();
        chk("wrap_done", flags(), 32'b010);
        rd(17'h0, d);            chk("wrap_w0", d, 32'h0101_000C);
        rd(wa(2046, 0), d);      chk("wrap_w2046", d & 32'hFFFF, 32'hA);
        rd(wa(2047, 0), d);      chk("wrap_w2047", d & 32'hFFFF, 32'hB);

        // Zero batch
        go(5'd31, 11'd0, 6'd0);
        chk("zero_busy", flags(), 32'b100);
        tick();
        chk("zero_done", flags(), 32'b010);

        // Start while collecting is ignored
        go(5'd0, 11'd10, 6'd2);
        lane0(16'h0111);
        last_row = 5'd31; addr_start = 11'd20; batch = 6'd5; start = 1'b1;
        result_out_valid[0] = 1'b1; result_out[15:0] = 16'h0222;
        tick();
        start = 1'b0; result_out_valid = '0;
        chk("ign_busy", flags(), 32'b100);
        tick();
        chk("ign_done", flags(), 32'b010);
        rd(wa(10, 0), d);        chk("ign_w10", d & 32'hFFFF, 32'h0111);
        rd(wa(11, 0), d);        chk("ign_w11", d & 32'hFFFF, 32'h0222);

        // Excess valid: second word must not land in word 1
        go(5'd0, 11'd0, 6'd1);
        lane0(16'h0AAA); lane0(16'h0BBB);
        chk("excess_flags", flags(), 32'b011);
        rd(wa(0, 0), d);         chk("excess_w0", d, 32'h0101_0AAA);
        rd(wa(1, 0), d);         chk("excess_w1", d, 32'h0201_0200);

        // Late valid after DONE
        go(5'd0, 11'd2, 6'd1);
        lane0(16'h0CCC);
        tick();
        chk("late_clean", flags(), 32'b010);
        lane0(16'h0DDD);
        chk("late_overrun", flags(), 32'b011);
        rd(wa(2, 0), d);         chk("late_w2", d, 32'h0012_0CCC);
        rd(wa(3, 0), d);         chk("late_w3", d, 32'h0013_0003);

        // Collision: read of word 5 same cycle as overwrite returns old data
        go(5'd0, 11'd5, 6'd1);
        lane0(16'h0042);
        tick();
        go(5'd0, 11'd5, 6'd1);
        result_out_valid[0] = 1'b1; result_out[15:0] = 16'h1234;
        s_en = 1'b1; s_addr = wa(5, 0);
        tick();
        result_out_valid = '0; s_en = 1'b0;
        tick();
        chk("coll_old", s_dout & 32'hFFFF, 32'h0042);
        chk("coll_done", flags(), 32'b010);
        rd(wa(5, 0), d);         chk("coll_new", d & 32'hFFFF, 32'h1234);

        // Reset mid-collection with a read in flight
        go(5'd0, 11'd0, 6'd4);
        result_out_valid[5] = 1'b1; s_en = 1'b1; s_addr = 17'h0;
        tick();
        result_out_valid = '0; s_en = 1'b0;
        chk("rst_pre", flags(), 32'b101);
        reset = 1'b1;
        tick();
        chk("rst_flags", flags(), 32'b000);
        chk("rst_dout", s_dout, 32'h0);
        reset = 1'b0;
        tick();
        chk("rst_idle", flags(), 32'b000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
